neuron_system: RTL and testbench
================================

NEURON_SYSTEM -- requirements
Module: neuron_system

Interface
REQ-001 SHALL provide port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL provide port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL provide port pixel_value, input, 16 bits: unsigned pixel intensity driving the rate encoder.
REQ-004 SHALL provide ports weight1 and weight2, input, 32 bits each: IEEE-754 single-precision synaptic weights for neuron 1 and neuron 2.
REQ-005 SHALL provide ports threshold1 and threshold2, input, 32 bits each: IEEE-754 single-precision firing thresholds.
REQ-006 SHALL provide ports leak_value1 and leak_value2, input, 32 bits each: IEEE-754 single-precision per-cycle leak amounts.
REQ-007 SHALL provide ports tref1 and tref2, input, 8 bits each: unsigned refractory period in cycles.
REQ-008 SHALL provide ports memb_potential_out1 and memb_potential_out2, output, 32 bits each: registered membrane potentials in IEEE-754 single precision.
REQ-009 SHALL provide ports spike_out1 and spike_out2, output, 1 bit each: registered spike flags, high for one cycle per firing.
REQ-010 SHALL provide ports tr1 and tr2, output, 8 bits each: remaining refractory cycles.
REQ-011 SHALL provide port spike_train, output, 1 bit: rate-encoded input spike.
REQ-012 SHALL provide port random_number, output, 16 bits: current LFSR state.

Function
REQ-013 SHALL implement a 16-bit Fibonacci LFSR with polynomial x^16+x^14+x^13+x^11+1 (feedback = bit15^bit13^bit12^bit10, shifted into bit0); it advances every cycle and never reaches 0.
REQ-014 SHALL drive spike_train combinationally as 1 when random_number < pixel_value (unsigned), else 0; pixel_value 0 never spikes.
REQ-015 SHALL use spike_train as the input of neuron 1, and the registered spike_out1 as the input of neuron 2 (one cycle of delay between stages).
REQ-016 SHALL run each neuron as a leaky integrate-and-fire unit with one state register V and one 8-bit counter tr.
REQ-017 SHALL, while tr > 0, decrement tr by 1 and hold V = +0.0 and the spike output at 0; input spikes arriving during this time are discarded.
REQ-018 SHALL, while tr = 0, compute V' = V + (input ? weight : 0.0) - leak, clamped to +0.0 when the result is negative.
REQ-019 SHALL, when V' >= threshold (float compare), set spike = 1, V = +0.0 and tr = tref on that edge; otherwise set spike = 0 and V = V'.
REQ-020 SHALL, when tref = 0, allow firing again on the next cycle.
REQ-021 SHALL accept only non-negative normal or zero float operands; denormal inputs and results are flushed to +0.0; rounding is truncation toward zero; NaN and Inf inputs are not supported.
REQ-022 SHALL treat an exactly equal threshold as firing (12.0 >= 12.0).

Reset
REQ-023 SHALL, while rst is high, asynchronously set the LFSR to 16'hACE1, V1 and V2 to 32'h00000000, spike_out1 and spike_out2 to 0, and tr1 and tr2 to 0.
REQ-024 SHALL resume normal operation on the first rising clock edge after rst falls; a reset asserted mid-refractory or mid-integration discards all state.

Configuration
REQ-025 SHALL, with macro NEURON_SYSTEM_LEAK_EN defined, subtract leak as in REQ-018.
REQ-026 SHALL, without NEURON_SYSTEM_LEAK_EN, omit the leak subtractor and ignore leak_value1 and leak_value2 (pure integrate-and-fire).

Verification
REQ-027 SHALL check: reset, then pixel_value = 0 for 100 cycles -> spike_train, spike_out1 and spike_out2 stay 0 and memb_potential_out1 = memb_potential_out2 = 0.
REQ-028 SHALL check: after reset, random_number = 16'hACE1, and the sequence matches a reference LFSR model for 1000 cycles with no zero state.
REQ-029 SHALL check: neuron 1 with weight 4.0 (0x40800000), threshold 12.0 (0x41400000), leak 0.0, tref 2 and spike_train held 1 -> memb_potential_out1 reads 4.0, then 8.0, then fires (spike_out1 = 1, memb 0), then tr1 = 2, 1, 0, then the cycle repeats.
REQ-030 SHALL check leak, with weight 4.0, leak 0.5 and threshold 5.0: input spike -> 3.5 (0x40600000); no input -> 3.0, 2.5, ... clamped at 0.0, never negative; a second spike from 3.5 -> fires.
REQ-031 SHALL check the cascade, with weight2 4.0, threshold2 5.0 (0x40A00000) and leak2 0.0: the first spike_out1 pulse -> memb_potential_out2 = 4.0 one cycle later; the second pulse -> spike_out2 = 1.
REQ-032 SHALL check: rst asserted asynchronously while tr1 = 1 -> all outputs clear immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/neuron_system.sv
// neuron_system: LFSR rate encoder driving two cascaded leaky integrate-and-fire neurons in IEEE-754 single precision.
// Leak subtraction is built only when NEURON_SYSTEM_LEAK_EN is defined; otherwise the neurons are pure integrate-and-fire.
module neuron_system_lif (
    input  logic        clk,
    input  logic        rst,
    input  logic        spike_in,
    input  logic [31:0] weight,
    input  logic [31:0] threshold,
    input  logic [31:0] leak,
    input  logic [7:0]  tref,
    output logic [31:0] v,
    output logic        spike,
    output logic [7:0]  tr
);
    function automatic logic [31:0] flush(input logic [31:0] x);
        return (x[31] || x[30:23] == 8'd0) ? 32'h0 : x;
    endfunction

    // Non-negative add/subtract, truncating toward zero; a negative difference clamps to +0.0.
    // The 26 extra low bits plus a sticky borrow keep subtraction truncation exact.
    function automatic logic [31:0] fp_op(input logic [31:0] x, input logic [31:0] y, input logic sub);
        logic [31:0] a, b, res;
        logic [7:0]  d;
        logic [50:0] ma, mb0, mb, r;
        logic        lost;
        int          p, e;
        a = flush(x);
        b = flush(y);
        if (!sub && b > a) begin
            a = flush(y);
            b = flush(x);
        end
        res = 32'h0;
        if (sub && b > a)
            res = 32'h0;
        else if (b[30:23] == 8'd0)
            res = a;
        else begin
            d    = a[30:23] - b[30:23];
            ma   = {2'b01, a[22:0], 26'b0};
            mb0  = {2'b01, b[22:0], 26'b0};
            mb   = mb0 >> d;
            lost = (mb << d) != mb0;
            r    = sub ? ma - mb - {50'b0, lost} : ma + mb;
            p    = 0;
            for (int i = 0; i < 51; i++)
                if (r[i]) p = i;
            e = int'({24'b0, a[30:23]}) + p - 49;
            r = r << (50 - p);
            res = (r == 51'b0 || e <= 0) ? 32'h0 : {1'b0, e[7:0], r[49:27]};
        end
        return res;
    endfunction

    logic [31:0] v_add, v_next;
    logic        fire;

    assign v_add = fp_op(v, spike_in ? weight : 32'h0, 1'b0);
`ifdef NEURON_SYSTEM_LEAK_EN
    assign v_next = fp_op(v_add, leak, 1'b1);
`else
    logic unused_leak;
    assign unused_leak = ^leak;
    assign v_next = v_add;
`endif
    assign fire = v_next >= flush(threshold);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v     <= 32'h0;
            spike <= 1'b0;
            tr    <= 8'd0;
        end else if (tr != 8'd0) begin
            v     <= 32'h0;
            spike <= 1'b0;
            tr    <= tr - 8'd1;
        end else if (fire) begin
            v     <= 32'h0;
            spike <= 1'b1;
            tr    <= tref;
        end else begin
            v     <= v_next;
            spike <= 1'b0;
        end
    end
endmodule

module neuron_system (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] pixel_value,
    input  logic [31:0] weight1,
    input  logic [31:0] weight2,
    input  logic [31:0] threshold1,
    input  logic [31:0] threshold2,
    input  logic [31:0] leak_value1,
    input  logic [31:0] leak_value2,
    input  logic [7:0]  tref1,
    input  logic [7:0]  tref2,
    output logic [31:0] memb_potential_out1,
    output logic [31:0] memb_potential_out2,
    output logic        spike_out1,
    output logic        spike_out2,
    output logic [7:0]  tr1,
    output logic [7:0]  tr2,
    output logic        spike_train,
    output logic [15:0] random_number
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            random_number <= 16'hACE1;
        else
            random_number <= {random_number[14:0],
                              random_number[15] ^ random_number[13] ^ random_number[12] ^ random_number[10]};
    end

    assign spike_train = random_number < pixel_value;

    neuron_system_lif u_n1 (
        .clk(clk), .rst(rst), .spike_in(spike_train),
        .weight(weight1), .threshold(threshold1), .leak(leak_value1), .tref(tref1),
        .v(memb_potential_out1), .spike(spike_out1), .tr(tr1)
    );

    neuron_system_lif u_n2 (
        .clk(clk), .rst(rst), .spike_in(spike_out1),
        .weight(weight2), .threshold(threshold2), .leak(leak_value2), .tref(tref2),
        .v(memb_potential_out2), .spike(spike_out2), .tr(tr2)
    );
endmodule

// File: tb/tb_neuron_system.sv
// tb_neuron_system: directed self-checking bench for neuron_system (rate encoder, LIF dynamics, cascade, async reset).
module tb_neuron_system;
    localparam logic [31:0] F0 = 32'h00000000, F4 = 32'h40800000, F8 = 32'h41000000,
                            F12 = 32'h41400000, F5 = 32'h40A00000, FH = 32'h3F000000, F100 = 32'h42C80000;

    logic        clk = 1'b0, rst = 1'b0;
    logic [15:0] pixel_value = 16'h0;
    logic [31:0] weight1 = F0, weight2 = F0, threshold1 = F100, threshold2 = F100, leak_value1 = F0, leak_value2 = F0;
    logic [7:0]  tref1 = 8'd0, tref2 = 8'd0;
    logic [31:0] memb_potential_out1, memb_potential_out2;
    logic        spike_out1, spike_out2, spike_train;
    logic [7:0]  tr1, tr2;
    logic [15:0] random_number;
    logic [15:0] model;
    int          n_tests = 0, n_fail = 0;

    neuron_system dut (
        .clk(clk), .rst(rst), .pixel_value(pixel_value),
        .weight1(weight1), .weight2(weight2), .threshold1(threshold1), .threshold2(threshold2),
        .leak_value1(leak_value1), .leak_value2(leak_value2), .tref1(tref1), .tref2(tref2),
        .memb_potential_out1(memb_potential_out1), .memb_potential_out2(memb_potential_out2),
        .spike_out1(spike_out1), .spike_out2(spike_out2), .tr1(tr1), .tr2(tr2),
        .spike_train(spike_train), .random_number(random_number)
    );

    always #5 clk = ~clk;

    // Cascade run (w1 4.0, th1 12.0, tref1 2; w2 4.0, th2 5.0, tref2 0), values after edges 1..11
    logic [31:0] c_v1 [1:11] = '{F4, F8, F0, F0, F0, F4, F8, F0, F0, F0, F4};
    logic        c_s1 [1:11] = '{0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0};
    logic [7:0]  c_t1 [1:11] = '{0, 0, 2, 1, 0, 0, 0, 2, 1, 0, 0};
    logic [31:0] c_v2 [1:11] = '{F0, F0, F0, F4, F4, F4, F4, F4, F0, F0, F0};
    logic        c_s2 [1:11] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};

    // Leak run (w1 4.0, leak1 0.5, th1 5.0, tref1 0): input spike on edges 1, 10, 11 only
    logic [15:0] l_px [1:11] = '{16'hFFFF, 0, 0, 0, 0, 0, 0, 0, 0, 16'hFFFF, 16'hFFFF};
`ifdef NEURON_SYSTEM_LEAK_EN
    logic [31:0] l_v1 [1:11] = '{32'h40600000, 32'h40400000, 32'h40200000, 32'h40000000, 32'h3FC00000,
                                 32'h3F800000, 32'h3F000000, F0, F0, 32'h40600000, F0};
    logic        l_s1 [1:11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
`else
    logic [31:0] l_v1 [1:11] = '{F4, F4, F4, F4, F4, F4, F4, F4, F4, F0, F4};
    logic        l_s1 [1:11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    initial begin
        // Reset state and silent input
        weight1 = F4; threshold1 = F12; tref1 = 8'd2; weight2 = F4; threshold2 = F5;
        pixel_value = 16'h0;
        do_reset();
        chk("rst_random", 32'(random_number), 32'hACE1);
        chk("rst_v1", memb_potential_out1, F0);
        chk("rst_v2", memb_potential_out2, F0);
        chk("rst_s1", 32'(spike_out1), 0);
        chk("rst_s2", 32'(spike_out2), 0);
        chk("rst_tr1", 32'(tr1), 0);
        chk("rst_tr2", 32'(tr2), 0);
        for (int k = 0; k < 100; k++) begin
            tick();
            chk($sformatf("quiet_train[%0d]", k), 32'(spike_train), 0);
            chk($sformatf("quiet_s1[%0d]", k), 32'(spike_out1), 0);
            chk($sformatf("quiet_s2[%0d]", k), 32'(spike_out2), 0);
            chk($sformatf("quiet_v1[%0d]", k), memb_potential_out1, F0);
            chk($sformatf("quiet_v2[%0d]", k), memb_potential_out2, F0);
        end

        // LFSR sequence against reference, with a hand-computed first step
        pixel_value = 16'h8000;
        do_reset();
        chk("lfsr_seed", 32'(random_number), 32'hACE1);
        tick();
        chk("lfsr_step1", 32'(random_number), 32'h59C3);
        model = 16'h59C3;
        for (int k = 0; k < 999; k++) begin
            tick();
            model = lfsr_next(model);
            chk($sformatf("lfsr[%0d]", k), 32'(random_number), 32'(model));
            chk($sformatf("lfsr_nz[%0d]", k), 32'(random_number != 16'h0), 1);
            chk($sformatf("train[%0d]", k), 32'(spike_train), 32'(model < pixel_value));
        end

        // Integrate, fire, refractory and cascade into neuron 2
        weight1 = F4; threshold1 = F12; leak_value1 = F0; tref1 = 8'd2;
        weight2 = F4; threshold2 = F5; leak_value2 = F0; tref2 = 8'd0;
        pixel_value = 16'hFFFF;
        do_reset();
        for (int k = 1; k <= 11; k++) begin
            tick();
            chk($sformatf("casc_train[%0d]", k), 32'(spike_train), 1);
            chk($sformatf("casc_v1[%0d]", k), memb_potential_out1, c_v1[k]);
            chk($sformatf("casc_s1[%0d]", k), 32'(spike_out1), 32'(c_s1[k]));
            chk($sformatf("casc_tr1[%0d]", k), 32'(tr1), 32'(c_t1[k]));
            chk($sformatf("casc_v2[%0d]", k), memb_potential_out2, c_v2[k]);
            chk($sformatf("casc_s2[%0d]", k), 32'(spike_out2), 32'(c_s2[k]));
        end

        // tref 0: neuron 1 fires on consecutive cycles, neuron 2 re-integrates right after firing
        weight1 = F12; threshold1 = F12; tref1 = 8'd0;
        do_reset();
        tick();
        chk("t0_s1_e1", 32'(spike_out1), 1);
        chk("t0_v1_e1", memb_potential_out1, F0);
        tick();
        chk("t0_s1_e2", 32'(spike_out1), 1);
        chk("t0_tr1_e2", 32'(tr1), 0);
        chk("t0_v2_e2", memb_potential_out2, F4);
        tick();
        chk("t0_s1_e3", 32'(spike_out1), 1);
        chk("t0_s2_e3", 32'(spike_out2), 1);
        chk("t0_v2_e3", memb_potential_out2, F0);
        tick();
        chk("t0_s2_e4", 32'(spike_out2), 0);
        chk("t0_v2_e4", memb_potential_out2, F4);

        // Leak decay, clamp at zero, and fire from 3.5 (pure integration when leak is not built)
        weight1 = F4; threshold1 = F5; leak_value1 = FH; tref1 = 8'd0;
        weight2 = F0; threshold2 = F100;
        do_reset();
        for (int k = 1; k <= 11; k++) begin
            pixel_value = l_px[k];
            tick();
            chk($sformatf("leak_v1[%0d]", k), memb_potential_out1, l_v1[k]);
            chk($sformatf("leak_s1[%0d]", k), 32'(spike_out1), 32'(l_s1[k]));
        end

        // Asynchronous reset mid-refractory clears everything without a clock edge
        weight1 = F4; threshold1 = F12; leak_value1 = F0; tref1 = 8'd2;
        weight2 = F4; threshold2 = F5; pixel_value = 16'hFFFF;
        do_reset();
        for (int k = 0; k < 4; k++) tick();
        chk("ar_pre_tr1", 32'(tr1), 1);
        chk("ar_pre_v2", memb_potential_out2, F4);
        #2 rst = 1'b1;
        #1;
        chk("ar_tr1", 32'(tr1), 0);
        chk("ar_v1", memb_potential_out1, F0);
        chk("ar_v2", memb_potential_out2, F0);
        chk("ar_s1", 32'(spike_out1), 0);
        chk("ar_s2", 32'(spike_out2), 0);
        chk("ar_tr2", 32'(tr2), 0);
        chk("ar_random", 32'(random_number), 32'hACE1);
        tick();
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
